// File: rtl/automorph_permute_buffer.sv
`default_nettype none
// ============================================================================
// Module      : automorph_permute_buffer
// Description : Two-bank ping-pong permutation buffer. Coefficients arrive
//               tagged with their permuted destination address and are
//               scattered into the bank being filled; a full bank is drained
//               in natural address order on a valid/ready stream while the
//               other bank fills with the next frame.
//               Optional duplicate-address detection is compiled in with the
//               macro APB_COLLISION_CHECK_EN (err_collision tied low otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module automorph_permute_buffer #(
  parameter int DATA_WIDTH = 54,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,            // asynchronous, active low
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  err_collision
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam int                    C_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] C_CNT_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   C_PTR_ONE   = (ADDR_WIDTH + 1)'(1);

  // Life cycle of one bank: filled by the writer, then handed to the reader.
  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_FULL     = 2'd2,
    S_DRAINING = 2'd3
  } bank_state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  bank_state_t           r_bank_state [2];
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  // One bit wider than an address so that "all words issued" is representable
  // while the last words are still waiting in the output path.
  logic [ADDR_WIDTH:0]   r_rd_ptr;

  // Both banks live in one array; the bank select is the address MSB.
  logic [DATA_WIDTH-1:0] r_mem [2*C_DEPTH];

  // Output register and its one-entry skid.
  logic                  r_out_vld;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_skid_vld;
  logic [ADDR_WIDTH-1:0] r_skid_addr;
  logic [DATA_WIDTH-1:0] r_skid_data;

  logic                  r_frame_done;

  // --------------------------------------------------------------------------
  // Write-side decode
  // --------------------------------------------------------------------------
  bank_state_t           w_wr_state;
  logic                  w_wr_open;
  logic                  w_wr_fire;
  logic                  w_wr_last;
  logic [ADDR_WIDTH:0]   w_wr_idx;

  assign w_wr_state = r_bank_state[r_wr_bank];
  assign w_wr_open  = (w_wr_state == S_EMPTY) || (w_wr_state == S_FILLING);
  // Held low while reset is asserted so every output reads 0 during reset.
  assign in_ready   = rst && w_wr_open;
  assign w_wr_fire  = in_valid && in_ready;
  assign w_wr_last  = w_wr_fire && (r_wr_cnt == C_LAST_ADDR);
  assign w_wr_idx   = {r_wr_bank, in_addr};

  // --------------------------------------------------------------------------
  // Read-side decode
  // --------------------------------------------------------------------------
  bank_state_t           w_rd_state;
  logic                  w_rd_avail;
  logic                  w_out_fire;
  logic                  w_out_free;
  logic                  w_path_space;
  logic                  w_rd_issue;
  logic                  w_land_out;
  logic                  w_land_skid;
  logic                  w_skid_to_out;
  logic                  w_drain_done;
  logic [ADDR_WIDTH:0]   w_rd_idx;

  assign w_rd_state   = r_bank_state[r_rd_bank];
  assign w_rd_avail   = ((w_rd_state == S_FULL) || (w_rd_state == S_DRAINING)) &&
                        !r_rd_ptr[ADDR_WIDTH];
  assign w_out_fire   = r_out_vld && out_ready;
  // The output register may take a new word this cycle.
  assign w_out_free   = !r_out_vld || out_ready;
  // A read may be launched only if its word is guaranteed a slot next cycle.
  assign w_path_space = !r_out_vld || (out_ready && !r_skid_vld);
  assign w_rd_issue   = w_rd_avail && w_path_space;
  // Skid content always has priority over fresh RAM data to keep order.
  assign w_land_out   = w_rd_issue && w_out_free && !r_skid_vld;
  assign w_land_skid  = w_rd_issue && !w_land_out;
  assign w_skid_to_out = r_skid_vld && w_out_free;
  assign w_drain_done = w_out_fire && (r_out_addr == C_LAST_ADDR);
  assign w_rd_idx     = {r_rd_bank, r_rd_ptr[ADDR_WIDTH-1:0]};

  // --------------------------------------------------------------------------
  // Bank life cycle, write counter and read pointer
  // --------------------------------------------------------------------------
  // Writer and reader never act on the same bank in one cycle: the writer only
  // touches EMPTY/FILLING banks and the reader only FULL/DRAINING ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank_state[0] <= S_EMPTY;
      r_bank_state[1] <= S_EMPTY;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_wr_cnt        <= '0;
      r_rd_ptr        <= '0;
    end else begin
      if (w_wr_fire) begin
        r_bank_state[r_wr_bank] <= w_wr_last ? S_FULL : S_FILLING;
        r_wr_cnt                <= r_wr_cnt + C_CNT_ONE;  // wraps to 0 on the last word
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end

      if (w_drain_done) begin
        r_bank_state[r_rd_bank] <= S_EMPTY;
        r_rd_ptr                <= '0;
        r_rd_bank               <= ~r_rd_bank;
      end else if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        if (w_rd_state == S_FULL) begin
          r_bank_state[r_rd_bank] <= S_DRAINING;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM array: scatter write, synchronous read into output register or skid
  // --------------------------------------------------------------------------
  // Data registers carry no reset; their valid flags qualify them and out_data
  // is masked while the output register is empty.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_idx] <= in_data;
    end
    if (w_out_free) begin
      if (r_skid_vld) begin
        r_out_data <= r_skid_data;
      end else if (w_land_out) begin
        r_out_data <= r_mem[w_rd_idx];
      end
    end
    if (w_land_skid) begin
      r_skid_data <= r_mem[w_rd_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Output register / skid control: valid flags and natural-order addresses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld   <= 1'b0;
      r_out_addr  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_addr <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_vld) begin
          r_out_vld  <= 1'b1;
          r_out_addr <= r_skid_addr;
        end else if (w_land_out) begin
          r_out_vld  <= 1'b1;
          r_out_addr <= r_rd_ptr[ADDR_WIDTH-1:0];
        end else begin
          r_out_vld  <= 1'b0;
        end
      end

      if (w_land_skid) begin
        r_skid_vld  <= 1'b1;
        r_skid_addr <= r_rd_ptr[ADDR_WIDTH-1:0];
      end else if (w_skid_to_out) begin
        r_skid_vld  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame-complete pulse, one cycle after the last word of a frame is written
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wr_last;
    end
  end

  // --------------------------------------------------------------------------
  // Duplicate-address detection
  // --------------------------------------------------------------------------
`ifdef APB_COLLISION_CHECK_EN
  logic [C_DEPTH-1:0] r_wr_mask [2];
  logic               r_err_collision;
  logic               w_collision;

  assign w_collision = w_wr_fire && r_wr_mask[r_wr_bank][in_addr];

  // Track which addresses of the filling bank were written; a repeat hit sets
  // the sticky flag. The mask is cleared when the bank completes, so the
  // next frame in that bank starts with a clean record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_mask[0]    <= '0;
      r_wr_mask[1]    <= '0;
      r_err_collision <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_mask[r_wr_bank] <= '0;
        end else begin
          r_wr_mask[r_wr_bank][in_addr] <= 1'b1;
        end
      end
      if (w_collision) begin
        r_err_collision <= 1'b1;
      end
    end
  end

  assign err_collision = r_err_collision;
`else
  assign err_collision = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign out_valid  = r_out_vld;
  assign out_addr   = r_out_addr;
  assign out_data   = r_out_vld ? r_out_data : '0;
  assign out_last   = r_out_vld && (r_out_addr == C_LAST_ADDR);
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_automorph_permute_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_automorph_permute_buffer
// Description : Self-checking bench for automorph_permute_buffer with a
//               frame-level reference model (frames held, expected word queue)
//               and directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_automorph_permute_buffer;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          frame_done;
  logic          err_collision;

  automorph_permute_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_addr       (in_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .err_collision (err_collision)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frames are collected by address; a complete frame is
  // queued in natural order. The buffer can hold two complete frames, so the
  // writer is ready whenever fewer than two frames are held.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            def;
  } item_t;

  item_t         expq[$];
  logic [DW-1:0] part_data [DEPTH];
  bit            part_def  [DEPTH];
  int            part_cnt;
  int            held;
  bit            fd_next;
  bit            exp_err;
  int            cyc = 0;
  int            lat_lo_at = -1;
  int            lat_hi_at = -1;
  bit            stalled;
  logic [DW-1:0] st_data;
  logic [AW-1:0] st_addr;
  logic          st_last;

  // Observations used by the literal checks of each scenario.
  logic [DW-1:0] cap_data[$];
  logic [AW-1:0] cap_addr[$];
  logic          cap_last[$];
  int            fd_count;
  int            in_acc;
  int            fill_cyc;
  int            first_out_cyc;

  function automatic logic [DW-1:0] cap_at(input int k);
    return (k < cap_data.size()) ? cap_data[k] : 'x;
  endfunction

  task automatic model_clear();
    expq.delete();
    for (int k = 0; k < DEPTH; k++) part_def[k] = 1'b0;
    part_cnt  = 0;
    held      = 0;
    fd_next   = 1'b0;
    exp_err   = 1'b0;
    stalled   = 1'b0;
    lat_lo_at = -1;
    lat_hi_at = -1;
  endtask

  task automatic clear_obs();
    cap_data.delete();
    cap_addr.delete();
    cap_last.delete();
    fd_count      = 0;
    in_acc        = 0;
    fill_cyc      = -1;
    first_out_cyc = -1;
  endtask

  // Single compare process: checks every cycle on the falling edge, then
  // advances the model with the handshakes that complete at the next rise.
  always @(negedge clk) begin : compare
    item_t it;
    bit    exp_rdy;
    bit    drained;
    cyc++;
    if (!rst) begin
      chk("reset_outputs", {out_valid, in_ready, out_last, frame_done, err_collision, out_addr, out_data}, '0);
      model_clear();
    end else begin
      exp_rdy = (held < 2);
      chk("in_ready", in_ready, exp_rdy);
      chk("frame_done", frame_done, fd_next);
      chk("err_collision", err_collision, exp_err);
      if (cyc == lat_lo_at) chk("latency_quiet", out_valid, 1'b0);
      if (cyc == lat_hi_at) chk("latency_first_valid", out_valid, 1'b1);
      if (stalled) chk("stall_hold", {out_valid, out_last, out_addr, out_data}, {1'b1, st_last, st_addr, st_data});
      if (frame_done) fd_count++;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;

      drained = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got addr %0d data %0h, expected no word", out_addr, out_data);
        end else begin
          it = expq.pop_front();
          chk("out_addr", out_addr, it.addr);
          chk("out_last", out_last, it.addr == AW'(DEPTH - 1));
          if (it.def) chk("out_data", out_data, it.data);
          drained = (it.addr == AW'(DEPTH - 1));
        end
        cap_data.push_back(out_data);
        cap_addr.push_back(out_addr);
        cap_last.push_back(out_last);
      end
      stalled = out_valid && !out_ready;
      st_data = out_data;
      st_addr = out_addr;
      st_last = out_last;

      fd_next = 1'b0;
      if (drained) held--;
      if (in_valid && exp_rdy) begin
        in_acc++;
`ifdef APB_COLLISION_CHECK_EN
        if (part_def[in_addr]) exp_err = 1'b1;
`endif
        part_data[in_addr] = in_data;
        part_def[in_addr]  = 1'b1;
        part_cnt++;
        if (part_cnt == DEPTH) begin
          for (int k = 0; k < DEPTH; k++)
            expq.push_back('{addr: AW'(k), data: part_data[k], def: part_def[k]});
          if (held == 0) begin
            lat_lo_at = cyc + 1;
            lat_hi_at = cyc + 2;
          end
          held++;
          fd_next  = 1'b1;
          fill_cyc = cyc;
          part_cnt = 0;
          for (int k = 0; k < DEPTH; k++) part_def[k] = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drivers (called at posedge + 1)
  // --------------------------------------------------------------------------
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget = 200;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL send_timeout: addr %0d not accepted within 200 cycles, expected acceptance", a);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    while ((expq.size() != 0 || out_valid) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", expq.size());
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin : stim
    logic [DW-1:0] t1_exp [4];
    logic [DW-1:0] t4_exp [4];
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 1: single permuted frame, addresses 3,1,0,2 carrying A,B,C,D
    clear_obs();
    out_ready = 1'b1;
    send(2'd3, 16'h00A1);
    send(2'd1, 16'h00B2);
    send(2'd0, 16'h00C3);
    send(2'd2, 16'h00D4);
    wait_drain(30);
    t1_exp = '{16'h00C3, 16'h00B2, 16'h00D4, 16'h00A1};
    chk("t1_count", cap_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_data", cap_at(k), t1_exp[k]);
      chk("t1_addr", (k < cap_addr.size()) ? cap_addr[k] : 'x, k);
      chk("t1_last", (k < cap_last.size()) ? cap_last[k] : 'x, k == 3);
    end
    chk("t1_frame_done_pulses", fd_count, 1);
    chk("t1_first_latency", first_out_cyc - fill_cyc, 2);

    // 2: three back-to-back identity frames with out_ready held high
    clear_obs();
    for (int f = 0; f < 3; f++)
      for (int a = 0; a < DEPTH; a++)
        send(AW'(a), DW'(16'h1000 + f * 16 + a));
    wait_drain(40);
    chk("t2_count", cap_data.size(), 12);
    for (int k = 0; k < 12; k++)
      chk("t2_data", cap_at(k), 16'h1000 + (k / 4) * 16 + (k % 4));
    chk("t2_frame_done_pulses", fd_count, 3);

    // 3: backpressure, both banks fill and the writer stalls
    clear_obs();
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < DEPTH; a++)
        send(AW'(a), DW'(16'h2000 + f * 16 + a));
    in_valid = 1'b1;
    in_addr  = '0;
    in_data  = 16'h2020;
    repeat (4) begin
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 1'b0);
    end
    chk("t3_accepted_before_stall", in_acc, 8);
    chk("t3_nothing_out_yet", cap_data.size(), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      send(AW'(a), DW'(16'h2020 + a));
    wait_drain(60);
    chk("t3_count", cap_data.size(), 12);
    for (int k = 0; k < 12; k++)
      chk("t3_data", cap_at(k), 16'h2000 + (k / 4) * 16 + (k % 4));

    // 4: out_ready toggling during the drain
    clear_obs();
    out_ready = 1'b1;
    send(2'd2, 16'h3A00);
    send(2'd0, 16'h3A01);
    send(2'd3, 16'h3A02);
    send(2'd1, 16'h3A03);
    repeat (12) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain(30);
    t4_exp = '{16'h3A01, 16'h3A03, 16'h3A00, 16'h3A02};
    chk("t4_count", cap_data.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t4_data", cap_at(k), t4_exp[k]);

    // 5: reset in the middle of a frame, then a full new frame
    clear_obs();
    send(2'd0, 16'hDEAD);
    send(2'd1, 16'hBEEF);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      send(AW'(a), DW'(16'h5000 + a));
    wait_drain(30);
    chk("t5_count", cap_data.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("t5_data", cap_at(k), 16'h5000 + k);
    chk("t5_frame_done_pulses", fd_count, 1);

    // 6: duplicate address within a frame (0,1,1,3)
    clear_obs();
    send(2'd0, 16'h6000);
    send(2'd1, 16'h6001);
    chk("t6_err_before_dup", err_collision, 1'b0);
    send(2'd1, 16'h6111);
`ifdef APB_COLLISION_CHECK_EN
    chk("t6_err_after_dup", err_collision, 1'b1);
`else
    chk("t6_err_after_dup", err_collision, 1'b0);
`endif
    send(2'd3, 16'h6003);
    wait_drain(30);
    chk("t6_count", cap_data.size(), 4);
    chk("t6_addr0", cap_at(0), 16'h6000);
    chk("t6_addr1_last_wins", cap_at(1), 16'h6111);
    chk("t6_addr3", cap_at(3), 16'h6003);
    repeat (5) @(posedge clk);
    #1;
`ifdef APB_COLLISION_CHECK_EN
    chk("t6_err_sticky", err_collision, 1'b1);
`else
    chk("t6_err_tied_low", err_collision, 1'b0);
`endif

    chk("leftover_expected", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
